// File: rtl/onebit_sequencer.sv
// onebit_sequencer
//   Sequences 5-bit instructions onto a downstream one-bit data register.
//   Each accepted instruction walks IDLE -> EXEC -> WB -> IDLE, so one
//   instruction is accepted at most every 3 cycles. This gap guarantees that
//   the next EXEC already sees the register value written by the previous WB.
//
//   Build option: define ONEBIT_ADD_EN to enable opcode 7 (ADD) and the carry
//   flag. When it is undefined, opcode 7 is illegal, carry is tied to 0 and
//   CLC behaves as a NOP.
//
// Parameters
//   ILLEGAL_HALT : 0 = illegal opcode behaves as a NOP and pulses illegal
//                  1 = illegal opcode sends the sequencer to HALT
// Ports
//   clk          : clock, all state changes on posedge
//   reset        : synchronous active-high reset
//   instr_valid  : an instruction is offered
//   instr[4:0]   : [4:1] opcode, [0] immediate bit
//   instr_ready  : high only in IDLE; accept = instr_valid & instr_ready
//   reg_q        : current value of the downstream register
//   ext_in       : external input bit, used by LDX
//   set_p        : write strobe to the downstream register (WB cycle only)
//   data         : write data to the downstream register
//   carry        : carry flag
//   illegal      : one-cycle pulse during WB of an illegal opcode
//   halted       : sequencer is in HALT; only reset leaves it
module onebit_sequencer #(
    parameter int unsigned ILLEGAL_HALT = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [4:0] instr,
    output logic       instr_ready,
    input  logic       reg_q,
    input  logic       ext_in,
    output logic       set_p,
    output logic       data,
    output logic       carry,
    output logic       illegal,
    output logic       halted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HALT = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_LDX = 4'd2;
    localparam logic [3:0] OP_NOT = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_ADD = 4'd7;
    localparam logic [3:0] OP_CLC = 4'd8;
    localparam logic [3:0] OP_HLT = 4'd9;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_instr;
    logic       r_data;

    logic [3:0] w_op;
    logic       w_imm;
    logic       w_wr;     // opcode writes the downstream register
    logic       w_res;    // value to write
    logic       w_ill;    // opcode is illegal in this build
    logic       w_hlt;    // opcode is HLT

`ifdef ONEBIT_ADD_EN
    logic       r_carry;
    logic       w_cy_nxt;
`endif

    assign w_op  = r_instr[4:1];
    assign w_imm = r_instr[0];

    // Decode of the latched instruction. Only meaningful in EXEC/WB; the
    // write-enable and illegal flag do not depend on reg_q, so they can be
    // reused unchanged during WB.
    always_comb begin
        w_wr  = 1'b0;
        w_res = r_data;
        w_ill = 1'b0;
        w_hlt = 1'b0;
`ifdef ONEBIT_ADD_EN
        w_cy_nxt = r_carry;
`endif
        case (w_op)
            OP_NOP: ;
            OP_LDI: begin w_wr = 1'b1; w_res = w_imm;          end
            OP_LDX: begin w_wr = 1'b1; w_res = ext_in;         end
            OP_NOT: begin w_wr = 1'b1; w_res = ~reg_q;         end
            OP_AND: begin w_wr = 1'b1; w_res = reg_q & w_imm;  end
            OP_OR:  begin w_wr = 1'b1; w_res = reg_q | w_imm;  end
            OP_XOR: begin w_wr = 1'b1; w_res = reg_q ^ w_imm;  end
`ifdef ONEBIT_ADD_EN
            OP_ADD: begin
                w_wr     = 1'b1;
                w_res    = reg_q ^ w_imm ^ r_carry;
                w_cy_nxt = (reg_q & w_imm) | (reg_q & r_carry) | (w_imm & r_carry);
            end
            OP_CLC: w_cy_nxt = 1'b0;
`else
            OP_CLC: ;
`endif
            OP_HLT: w_hlt = 1'b1;
            default: w_ill = 1'b1;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (instr_valid) w_next = S_EXEC;
            S_EXEC: begin
                if (w_hlt || (w_ill && (ILLEGAL_HALT != 0)))
                    w_next = S_HALT;
                else
                    w_next = S_WB;
            end
            S_WB:   w_next = S_IDLE;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_instr <= 5'd0;
            r_data  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && instr_valid)
                r_instr <= instr;
            // Result is captured at the EXEC->WB edge and held otherwise.
            if (r_state == S_EXEC && w_wr)
                r_data <= w_res;
        end
    end

`ifdef ONEBIT_ADD_EN
    always_ff @(posedge clk) begin
        if (reset)
            r_carry <= 1'b0;
        else if (r_state == S_EXEC)
            r_carry <= w_cy_nxt;
    end
    assign carry = r_carry;
`else
    assign carry = 1'b0;
`endif

    assign instr_ready = (r_state == S_IDLE);
    assign set_p       = (r_state == S_WB) && w_wr;
    assign illegal     = (r_state == S_WB) && w_ill;
    assign halted      = (r_state == S_HALT);
    assign data        = r_data;

endmodule

// File: tb/tb_onebit_sequencer.sv
// Directed bench for onebit_sequencer. Two instances share the stimulus:
// dut (ILLEGAL_HALT=0) carries most checks, dut_h (ILLEGAL_HALT=1) is used
// for the illegal-opcode halt behaviour. Each instance drives its own model
// of the downstream one-bit register.
module tb_onebit_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [4:0] instr;
    logic       ext_in;

    logic instr_ready, set_p, data, carry, illegal, halted;
    logic reg_m = 1'b0;

    logic instr_ready_h, set_p_h, data_h, carry_h, illegal_h, halted_h;
    logic reg_h = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    onebit_sequencer #(.ILLEGAL_HALT(0)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .reg_q(reg_m), .ext_in(ext_in),
        .set_p(set_p), .data(data), .carry(carry), .illegal(illegal),
        .halted(halted)
    );

    onebit_sequencer #(.ILLEGAL_HALT(1)) dut_h (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready_h), .reg_q(reg_h), .ext_in(ext_in),
        .set_p(set_p_h), .data(data_h), .carry(carry_h), .illegal(illegal_h),
        .halted(halted_h)
    );

    // Downstream registers
    always_ff @(posedge clk) begin
        if (set_p)   reg_m <= data;
        if (set_p_h) reg_h <= data_h;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one instruction for one cycle, then sample the WB cycle.
    task automatic run(input logic [3:0] op, input logic imm,
                       output logic sp, output logic d, output logic il, output logic c);
        instr       = {op, imm};
        instr_valid = 1'b1;
        tick();                 // accept -> EXEC
        instr_valid = 1'b0;
        tick();                 // EXEC -> WB
        sp = set_p; d = data; il = illegal; c = carry;
        tick();                 // WB -> IDLE, downstream captures
    endtask

    initial begin
        logic sp, d, il, c;
        logic exp_d;
        int   sp_cnt, rdy_cnt;

        reset = 1'b1; instr_valid = 1'b0; instr = 5'd0; ext_in = 1'b0;
        tick();
        tick();
        chk("rst_set_p",   set_p,       1'b0);
        chk("rst_data",    data,        1'b0);
        chk("rst_carry",   carry,       1'b0);
        chk("rst_illegal", illegal,     1'b0);
        chk("rst_halted",  halted,      1'b0);
        chk("rst_ready",   instr_ready, 1'b1);
        reset = 1'b0;

        // LDI 1, then XOR 1 held valid so it is accepted at the earliest slot
        instr = {4'd1, 1'b1}; instr_valid = 1'b1;
        tick();                                   // edge k: accept LDI
        instr = {4'd6, 1'b1};                     // XOR 1 stays offered
        chk("ldi_exec_ready", instr_ready, 1'b0);
        chk("ldi_exec_set_p", set_p,       1'b0);
        tick();                                   // k+1: WB
        chk("ldi_wb_set_p",   set_p,       1'b1);
        chk("ldi_wb_data",    data,        1'b1);
        chk("ldi_wb_ready",   instr_ready, 1'b0);
        tick();                                   // k+2: IDLE
        chk("ldi_idle_set_p", set_p,       1'b0);
        chk("ldi_idle_ready", instr_ready, 1'b1);
        chk("ldi_reg",        reg_m,       1'b1);
        tick();                                   // k+3: accept XOR
        instr_valid = 1'b0;
        chk("xor_exec_set_p", set_p,       1'b0);
        chk("xor_exec_data",  data,        1'b1);
        tick();                                   // k+4: WB
        chk("xor_wb_set_p",   set_p,       1'b1);
        chk("xor_wb_data",    data,        1'b0);
        tick();
        chk("xor_reg",        reg_m,       1'b0);

        // Remaining logic opcodes
        ext_in = 1'b1;
        run(4'd2, 1'b0, sp, d, il, c);            // LDX, ext=1
        ext_in = 1'b0;
        chk("ldx_set_p", sp, 1'b1);
        chk("ldx_data",  d,  1'b1);
        run(4'd3, 1'b0, sp, d, il, c);            // NOT, reg=1
        chk("not_set_p", sp, 1'b1);
        chk("not_data",  d,  1'b0);
        run(4'd5, 1'b1, sp, d, il, c);            // OR 1, reg=0
        chk("or_data",   d,  1'b1);
        run(4'd4, 1'b0, sp, d, il, c);            // AND 0, reg=1
        chk("and_data",  d,  1'b0);
        run(4'd0, 1'b1, sp, d, il, c);            // NOP
        chk("nop_set_p",   sp, 1'b0);
        chk("nop_data",    d,  1'b0);
        chk("nop_illegal", il, 1'b0);

        run(4'd1, 1'b1, sp, d, il, c);            // LDI 1, reg=1
        chk("ldi2_data", d, 1'b1);
`ifdef ONEBIT_ADD_EN
        run(4'd8, 1'b0, sp, d, il, c);            // CLC
        chk("clc0_carry", c, 1'b0);
        run(4'd7, 1'b1, sp, d, il, c);            // ADD 1: 1+1+0
        chk("add_set_p", sp, 1'b1);
        chk("add_data",  d,  1'b0);
        chk("add_carry", c,  1'b1);
        run(4'd8, 1'b0, sp, d, il, c);            // CLC
        chk("clc_set_p", sp, 1'b0);
        chk("clc_carry", c,  1'b0);
        exp_d = 1'b0;
`else
        run(4'd7, 1'b1, sp, d, il, c);            // opcode 7 illegal here
        chk("op7_illegal", il, 1'b1);
        chk("op7_set_p",   sp, 1'b0);
        chk("op7_carry",   c,  1'b0);
        exp_d = 1'b1;
`endif

        // Illegal opcode 12
        run(4'd12, 1'b1, sp, d, il, c);
        chk("ill_pulse",   il, 1'b1);
        chk("ill_set_p",   sp, 1'b0);
        chk("ill_data",    d,  exp_d);
        chk("ill_after",   illegal, 1'b0);
        chk("illh_halted", halted_h,      1'b1);
        chk("illh_ready",  instr_ready_h, 1'b0);
        chk("ill_halted",  halted, 1'b0);

        // HLT, then a write instruction held valid for 5 cycles
        instr = {4'd9, 1'b0}; instr_valid = 1'b1;
        tick();                                   // accept HLT
        instr = {4'd1, 1'b1};
        tick();                                   // EXEC -> HALT
        chk("hlt_halted", halted,      1'b1);
        chk("hlt_ready",  instr_ready, 1'b0);
        sp_cnt = 0; rdy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (set_p)       sp_cnt++;
            if (instr_ready) rdy_cnt++;
        end
        chk("hlt_no_set_p", sp_cnt[7:0],  8'd0);
        chk("hlt_no_ready", rdy_cnt[7:0], 8'd0);
        chk("hlt_still",    halted,       1'b1);
        instr_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("hrst_halted",  halted,        1'b0);
        chk("hrst_ready",   instr_ready,   1'b1);
        chk("hrst_halted_h", halted_h,     1'b0);

        // Reset during WB of LDI 1, valid held through reset
        instr = {4'd1, 1'b1}; instr_valid = 1'b1;
        tick();                                   // accept
        tick();                                   // WB
        chk("wbr_set_p_pre", set_p, 1'b1);
        reset = 1'b1;
        tick();
        chk("wbr_set_p", set_p,       1'b0);
        chk("wbr_data",  data,        1'b0);
        chk("wbr_carry", carry,       1'b0);
        chk("wbr_ready", instr_ready, 1'b1);
        tick();                                   // reset beats accept
        chk("wbr_prio_ready", instr_ready, 1'b1);
        reset = 1'b0; instr_valid = 1'b0;
        tick();
        chk("wbr_end_set_p", set_p, 1'b0);
        chk("wbr_end_data",  data,  1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/onebit_sequencer.md
ONEBIT_SEQUENCER -- requirements
Module: onebit_sequencer

Interface
REQ-001 SHALL have parameter: ILLEGAL_HALT, 0, when 1 an illegal opcode enters HALT instead of acting as NOP.
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: instr_valid  input  1  instruction offered.
REQ-005 SHALL have port: instr  input  5  [4:1] opcode, [0] immediate bit.
REQ-006 SHALL have port: instr_ready  output  1  sequencer accepts instruction this cycle.
REQ-007 SHALL have port: reg_q  input  1  current value of the downstream one-bit data register.
REQ-008 SHALL have port: ext_in  input  1  external input bit.
REQ-009 SHALL have port: set_p  output  1  write strobe to the downstream register.
REQ-010 SHALL have port: data  output  1  write data to the downstream register.
REQ-011 SHALL have port: carry  output  1  carry flag.
REQ-012 SHALL have port: illegal  output  1  one-cycle pulse on illegal opcode.
REQ-013 SHALL have port: halted  output  1  sequencer in HALT.

Function
REQ-014 SHALL implement states IDLE, EXEC, WB, HALT; instr_ready = 1 only in IDLE.
REQ-015 SHALL accept on posedge with instr_valid=1 and instr_ready=1, latch instr, go IDLE->EXEC.
REQ-016 SHALL sample reg_q and ext_in during EXEC; at next edge register result into data, go EXEC->WB.
REQ-017 SHALL drive set_p=1 for exactly the WB cycle for writing opcodes, 0 otherwise; WB->IDLE next edge.
REQ-018 SHALL give latency: accept at edge k, set_p=1 between edges k+1 and k+2, register captures at k+2; throughput one instruction per 3 cycles.
REQ-019 SHALL guarantee read-after-write: earliest next accept is edge k+3, so its EXEC sees updated reg_q.
REQ-020 SHALL decode: 0 NOP, 1 LDI data=imm, 2 LDX data=ext_in, 3 NOT data=~reg_q, 4 AND reg_q&imm, 5 OR reg_q|imm, 6 XOR reg_q^imm, 7 ADD, 8 CLC, 9 HLT; 10-15 illegal.
REQ-021 SHALL for ADD: data = reg_q^imm^carry, carry <= majority(reg_q,imm,carry), updated at EXEC->WB edge.
REQ-022 SHALL for NOP, CLC and illegal (ILLEGAL_HALT=0): pass through WB with set_p=0; CLC clears carry at EXEC->WB edge.
REQ-023 SHALL pulse illegal=1 during the WB cycle of an illegal opcode.
REQ-024 SHALL for HLT (or illegal with ILLEGAL_HALT=1): EXEC->HALT, no set_p, halted=1, instr_ready=0 until reset.
REQ-025 SHALL hold data unchanged when set_p=0; carry changes only via ADD, CLC, reset.
REQ-026 SHALL ignore instr/instr_valid outside IDLE; a held valid is not double-accepted.

Reset
REQ-027 SHALL on reset=1 at posedge force: state IDLE, set_p=0, data=0, carry=0, illegal=0, halted=0; instr_ready=1 the following cycle.
REQ-028 SHALL abort any in-flight instruction on reset (including in WB): no write after reset edge; reset has priority over accept.

Configuration
REQ-029 SHALL use macro ONEBIT_ADD_EN: defined -> ADD opcode 7 and carry logic per REQ-021; undefined -> opcode 7 illegal, carry tied 0, CLC acts as NOP.

Verification
REQ-030 SHALL cover: reset, LDI imm=1 at edge 2 -> set_p=1, data=1 between edges 3-4, instr_ready=0 edges 2-4.
REQ-031 SHALL cover: reg_q=1, XOR imm=1 back-to-back after LDI -> data=0, set_p pulses 3 cycles apart.
REQ-032 SHALL cover (ONEBIT_ADD_EN): reg_q=1,carry=0, ADD imm=1 -> data=0, carry=1; CLC -> carry=0, no set_p.
REQ-033 SHALL cover: opcode 12 with ILLEGAL_HALT=0 -> illegal pulse, no set_p; ILLEGAL_HALT=1 -> halted=1, instr_ready=0.
REQ-034 SHALL cover: HLT then instr_valid held 5 cycles -> no accept; reset -> halted=0, instr_ready=1.
REQ-035 SHALL cover: reset asserted during WB of LDI imm=1 -> set_p=0 and data=0 after reset edge, carry=0.
